// File: rtl/sdram_apb_arbiter.sv
// Two-requester round-robin APB arbiter feeding the SDRAM controller slave port.
// Optional ACCESS-phase watchdog with DRAIN recovery: define SDRAM_APB_ARB_TIMEOUT_EN.
module sdram_apb_arbiter #(
   parameter int ADDR_W         = 32,
   parameter int DATA_W         = 32,
   parameter int TIMEOUT_CYCLES = 1024
) (
   input  logic                clock,
   input  logic                reset,
   input  logic                m0_psel,
   input  logic                m0_penable,
   input  logic                m0_pwrite,
   input  logic [ADDR_W-1:0]   m0_paddr,
   input  logic [2:0]          m0_pprot,
   input  logic [DATA_W-1:0]   m0_pwdata,
   input  logic [DATA_W/8-1:0] m0_pstrb,
   output logic                m0_pready,
   output logic                m0_pslverr,
   output logic [DATA_W-1:0]   m0_prdata,
   input  logic                m1_psel,
   input  logic                m1_penable,
   input  logic                m1_pwrite,
   input  logic [ADDR_W-1:0]   m1_paddr,
   input  logic [2:0]          m1_pprot,
   input  logic [DATA_W-1:0]   m1_pwdata,
   input  logic [DATA_W/8-1:0] m1_pstrb,
   output logic                m1_pready,
   output logic                m1_pslverr,
   output logic [DATA_W-1:0]   m1_prdata,
   output logic                out_psel,
   output logic                out_penable,
   output logic                out_pwrite,
   output logic [ADDR_W-1:0]   out_paddr,
   output logic [2:0]          out_pprot,
   output logic [DATA_W-1:0]   out_pwdata,
   output logic [DATA_W/8-1:0] out_pstrb,
   input  logic                out_pready,
   input  logic                out_pslverr,
   input  logic [DATA_W-1:0]   out_prdata
);

`ifdef SDRAM_APB_ARB_TIMEOUT_EN
   typedef enum logic [1:0] {IDLE, SETUP, ACCESS, DRAIN} state_t;
   localparam int CW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
   logic [CW-1:0] cnt;
`else
   typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_t;
`endif

   state_t state;
   logic   grant;
   logic   last;
   logic   active;
   logic   done;
   logic   timeout;
   logic   finish;
   logic   err;

   // Reset gates every output so nothing leaks while the synchronous reset is pending.
   assign active = !reset && (state == SETUP || state == ACCESS);
   assign done   = !reset && state == ACCESS && out_pready;
`ifdef SDRAM_APB_ARB_TIMEOUT_EN
   assign timeout = !reset && state == ACCESS && !out_pready && cnt == CW'(TIMEOUT_CYCLES - 1);
`else
   assign timeout = 1'b0;
`endif
   assign finish = done || timeout;
   assign err    = done ? out_pslverr : timeout;

   always_ff @(posedge clock) begin
      if (reset) begin
         state <= IDLE;
         grant <= 1'b0;
         last  <= 1'b1;
`ifdef SDRAM_APB_ARB_TIMEOUT_EN
         cnt   <= '0;
`endif
      end else begin
         case (state)
            IDLE: if (m0_psel || m1_psel) begin
               grant <= (m0_psel && m1_psel) ? ~last : m1_psel;
               state <= SETUP;
            end
            SETUP: begin
               state <= ACCESS;
`ifdef SDRAM_APB_ARB_TIMEOUT_EN
               cnt   <= '0;
`endif
            end
            ACCESS: begin
               if (out_pready) begin
                  last  <= grant;
                  state <= IDLE;
`ifdef SDRAM_APB_ARB_TIMEOUT_EN
               end else if (timeout) begin
                  last  <= grant;
                  state <= DRAIN;
               end else begin
                  cnt <= cnt + CW'(1);
`endif
               end
            end
`ifdef SDRAM_APB_ARB_TIMEOUT_EN
            // Late slave response is swallowed here; no new grant until it arrives.
            DRAIN: if (out_pready) state <= IDLE;
`endif
            default: state <= IDLE;
         endcase
      end
   end

   always_comb begin
      out_psel    = 1'b0;
      out_penable = 1'b0;
      out_pwrite  = 1'b0;
      out_paddr   = '0;
      out_pprot   = '0;
      out_pwdata  = '0;
      out_pstrb   = '0;
      if (active) begin
         out_psel    = 1'b1;
         out_penable = (state == ACCESS);
         if (grant) begin
            out_pwrite = m1_pwrite;
            out_paddr  = m1_paddr;
            out_pprot  = m1_pprot;
            out_pwdata = m1_pwdata;
            out_pstrb  = m1_pstrb;
         end else begin
            out_pwrite = m0_pwrite;
            out_paddr  = m0_paddr;
            out_pprot  = m0_pprot;
            out_pwdata = m0_pwdata;
            out_pstrb  = m0_pstrb;
         end
      end
      m0_pready  = finish && !grant;
      m1_pready  = finish && grant;
      m0_pslverr = err && !grant;
      m1_pslverr = err && grant;
      m0_prdata  = (done && !grant) ? out_prdata : '0;
      m1_prdata  = (done && grant) ? out_prdata : '0;
   end

endmodule

// File: tb/tb_sdram_apb_arbiter.sv
// Randomized self-checking bench for sdram_apb_arbiter with a transaction-level reference model.
module tb_sdram_apb_arbiter;
   logic        clock = 0;
   logic        reset = 1;
   logic        m0_psel = 0, m0_penable = 0, m0_pwrite = 0;
   logic [31:0] m0_paddr = 0, m0_pwdata = 0;
   logic [2:0]  m0_pprot = 0;
   logic [3:0]  m0_pstrb = 0;
   logic        m0_pready, m0_pslverr;
   logic [31:0] m0_prdata;
   logic        m1_psel = 0, m1_penable = 0, m1_pwrite = 0;
   logic [31:0] m1_paddr = 0, m1_pwdata = 0;
   logic [2:0]  m1_pprot = 0;
   logic [3:0]  m1_pstrb = 0;
   logic        m1_pready, m1_pslverr;
   logic [31:0] m1_prdata;
   logic        out_psel, out_penable, out_pwrite;
   logic [31:0] out_paddr, out_pwdata;
   logic [2:0]  out_pprot;
   logic [3:0]  out_pstrb;
   logic        out_pready = 0, out_pslverr = 0;
   logic [31:0] out_prdata = 0;

   sdram_apb_arbiter #(.ADDR_W(32), .DATA_W(32), .TIMEOUT_CYCLES(1024)) dut (
      .clock(clock), .reset(reset),
      .m0_psel(m0_psel), .m0_penable(m0_penable), .m0_pwrite(m0_pwrite), .m0_paddr(m0_paddr),
      .m0_pprot(m0_pprot), .m0_pwdata(m0_pwdata), .m0_pstrb(m0_pstrb),
      .m0_pready(m0_pready), .m0_pslverr(m0_pslverr), .m0_prdata(m0_prdata),
      .m1_psel(m1_psel), .m1_penable(m1_penable), .m1_pwrite(m1_pwrite), .m1_paddr(m1_paddr),
      .m1_pprot(m1_pprot), .m1_pwdata(m1_pwdata), .m1_pstrb(m1_pstrb),
      .m1_pready(m1_pready), .m1_pslverr(m1_pslverr), .m1_prdata(m1_prdata),
      .out_psel(out_psel), .out_penable(out_penable), .out_pwrite(out_pwrite), .out_paddr(out_paddr),
      .out_pprot(out_pprot), .out_pwdata(out_pwdata), .out_pstrb(out_pstrb),
      .out_pready(out_pready), .out_pslverr(out_pslverr), .out_prdata(out_prdata)
   );

   always #5 clock = ~clock;

   int compared = 0;
   int mismatched = 0;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      compared++;
      if (act !== exp) begin
         mismatched++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at cycle t=%0t", nm, act, exp, $time);
      end
   endtask

   // Slave: replies cur_wait cycles into ACCESS; random mode adds noise outside transfers.
   bit          rand_mode = 0;
   int          slv_wait = 1;
   logic [31:0] slv_data = 0;
   logic        slv_err = 0;
   int          acc_n = 0;
   int          cur_wait = 1;
   initial forever begin
      @(posedge clock); #2;
      if (out_psel && out_penable) begin
         acc_n++;
         if (acc_n == 1) cur_wait = rand_mode ? int'($urandom_range(1, 4)) : slv_wait;
         out_pready  = (acc_n >= cur_wait);
         out_prdata  = rand_mode ? $urandom : slv_data;
         out_pslverr = rand_mode ? 1'($urandom_range(0, 1)) : slv_err;
      end else begin
         acc_n       = 0;
         out_pready  = rand_mode ? 1'($urandom_range(0, 1)) : 1'b0;
         out_prdata  = $urandom;
         out_pslverr = 1'($urandom_range(0, 1));
      end
   end

   // Reference: who owns the downstream port and for how many cycles.
   int own = -1, age = 0, lst = 1, cyc = 0;
   int cnt_psel = 0, cnt_penlo = 0, cnt_strb3 = 0, cnt_err1 = 0;
   int cnt_rdy[2] = '{0, 0};
   int rdy_cyc[2] = '{0, 0};
   logic [31:0] cap_rd[2];
   int done_q[$];
   int su_q[$];

   always @(negedge clock) begin
      logic        e_sel, e_en, e_w, e_fin;
      logic [31:0] e_a, e_d;
      logic [2:0]  e_p;
      logic [3:0]  e_s;
      logic [1:0]  e_rdy, e_err;
      logic [31:0] e_rd0, e_rd1;
      {e_sel, e_en, e_w, e_fin, e_a, e_d, e_p, e_s, e_rdy, e_err, e_rd0, e_rd1} = '0;
      if (!reset && own >= 0) begin
         e_sel = 1;
         e_en  = (age > 0);
         e_w   = own ? m1_pwrite : m0_pwrite;
         e_a   = own ? m1_paddr  : m0_paddr;
         e_d   = own ? m1_pwdata : m0_pwdata;
         e_p   = own ? m1_pprot  : m0_pprot;
         e_s   = own ? m1_pstrb  : m0_pstrb;
         e_fin = (age > 0) && out_pready;
         if (e_fin) begin
            e_rdy[own] = 1'b1;
            e_err[own] = out_pslverr;
            if (own == 0) e_rd0 = out_prdata; else e_rd1 = out_prdata;
         end
      end
      chk("out_psel", 64'(out_psel), 64'(e_sel));
      chk("out_penable", 64'(out_penable), 64'(e_en));
      chk("out_pwrite", 64'(out_pwrite), 64'(e_w));
      chk("out_paddr", 64'(out_paddr), 64'(e_a));
      chk("out_pwdata", 64'(out_pwdata), 64'(e_d));
      chk("out_pprot", 64'(out_pprot), 64'(e_p));
      chk("out_pstrb", 64'(out_pstrb), 64'(e_s));
      chk("m0_pready", 64'(m0_pready), 64'(e_rdy[0]));
      chk("m1_pready", 64'(m1_pready), 64'(e_rdy[1]));
      chk("m0_pslverr", 64'(m0_pslverr), 64'(e_err[0]));
      chk("m1_pslverr", 64'(m1_pslverr), 64'(e_err[1]));
      chk("m0_prdata", 64'(m0_prdata), 64'(e_rd0));
      chk("m1_prdata", 64'(m1_prdata), 64'(e_rd1));
      // advance reference
      if (reset) begin
         own = -1; lst = 1; age = 0;
      end else if (own < 0) begin
         if (m0_psel && m1_psel) own = 1 - lst;
         else if (m0_psel) own = 0;
         else if (m1_psel) own = 1;
         age = 0;
      end else if (e_fin) begin
         lst = own; own = -1;
      end else age++;
      // DUT-side event log for the directed checks
      if (out_psel) cnt_psel++;
      if (out_psel && !out_penable) begin cnt_penlo++; su_q.push_back(cyc); end
      if (out_psel && out_pstrb == 4'b0011) cnt_strb3++;
      if (m1_pslverr) cnt_err1++;
      if (m0_pready) begin cnt_rdy[0]++; rdy_cyc[0] = cyc; cap_rd[0] = m0_prdata; done_q.push_back(0); end
      if (m1_pready) begin cnt_rdy[1]++; rdy_cyc[1] = cyc; cap_rd[1] = m1_prdata; done_q.push_back(1); end
      cyc++;
   end

   task automatic clr();
      cnt_psel = 0; cnt_penlo = 0; cnt_strb3 = 0; cnt_err1 = 0;
      cnt_rdy[0] = 0; cnt_rdy[1] = 0; done_q.delete(); su_q.delete();
   endtask

   task automatic drive(input int m, input logic sel, input logic en, input logic [31:0] a,
                        input logic w, input logic [31:0] d, input logic [3:0] s);
      if (m == 0) begin
         m0_psel = sel; m0_penable = en; m0_paddr = a; m0_pwrite = w;
         m0_pwdata = d; m0_pstrb = s; m0_pprot = a[2:0];
      end else begin
         m1_psel = sel; m1_penable = en; m1_paddr = a; m1_pwrite = w;
         m1_pwdata = d; m1_pstrb = s; m1_pprot = a[2:0];
      end
   endtask

   // APB-compliant requester; call at posedge+1, returns at posedge+1 after its pready.
   task automatic xfer(input int m, input logic [31:0] a, input logic w,
                       input logic [31:0] d, input logic [3:0] s);
      int n = 0;
      bit got = 0;
      drive(m, 1, 0, a, w, d, s);
      while (!got && n < 200) begin
         @(negedge clock);
         got = (m == 0) ? m0_pready : m1_pready;
         @(posedge clock); #1;
         n++;
         if (!got) drive(m, 1, 1, a, w, d, s);
      end
      if (!got) begin
         compared++; mismatched++;
         $display("FAIL xfer_timeout: m%0d got no pready within %0d cycles, expected one", m, n);
      end
      drive(m, 0, 0, 32'h0, 0, 32'h0, 4'h0);
   endtask

   task automatic do_reset(input int n);
      reset = 1;
      repeat (n) begin @(posedge clock); #1; end
      reset = 0;
   endtask

   initial begin
      int start;
      int n;
      @(posedge clock); #1;
      do_reset(3);
      @(negedge clock);
      chk("reset_psel", 64'(out_psel), 64'h0);
      chk("reset_m0_pready", 64'(m0_pready), 64'h0);
      @(posedge clock); #1;

      // lone read, slave answers on the 4th ACCESS cycle
      clr(); slv_wait = 4; slv_data = 32'h1234_5678;
      xfer(0, 32'hA000_0010, 0, 32'h0, 4'hF);
      chk("t1_psel_cycles", 64'(cnt_psel), 64'd5);
      chk("t1_setup_cycles", 64'(cnt_penlo), 64'd1);
      chk("t1_m0_pulses", 64'(cnt_rdy[0]), 64'd1);
      chk("t1_m1_pulses", 64'(cnt_rdy[1]), 64'd0);
      chk("t1_rdata", 64'(cap_rd[0]), 64'h1234_5678);

      // simultaneous requests right after reset
      do_reset(2);
      clr(); slv_wait = 1; start = cyc;
      fork
         xfer(0, 32'h0000_0100, 0, 32'h0, 4'hF);
         xfer(1, 32'h0000_0200, 0, 32'h0, 4'hF);
      join
      chk("t2_count", 64'(done_q.size()), 64'd2);
      if (done_q.size() == 2) begin
         chk("t2_first", 64'(done_q[0]), 64'd0);
         chk("t2_second", 64'(done_q[1]), 64'd1);
      end
      chk("t2_setups", 64'(su_q.size()), 64'd2);
      if (su_q.size() == 2) begin
         chk("t2_setup0_lat", 64'(su_q[0] - start), 64'd1);
         chk("t2_m1_setup_gap", 64'(su_q[1] - rdy_cyc[0]), 64'd2);
      end
      chk("t2_m0_done_lat", 64'(rdy_cyc[0] - start), 64'd2);

      // back-to-back writes from both: strict alternation
      clr();
      fork
         for (int i = 0; i < 4; i++) xfer(0, 32'h1000 + i * 4, 1, 32'hA0 + i, 4'hF);
         for (int i = 0; i < 4; i++) xfer(1, 32'h2000 + i * 4, 1, 32'hB0 + i, 4'h5);
      join
      chk("t3_count", 64'(done_q.size()), 64'd8);
      for (int i = 0; i < done_q.size() && i < 8; i++) chk("t3_order", 64'(done_q[i]), 64'(i % 2));

      // m1 partial write with slave error
      clr(); slv_wait = 2; slv_err = 1;
      xfer(1, 32'h3000, 1, 32'hDEAD_BEEF, 4'b0011);
      slv_err = 0;
      chk("t4_err_cycles", 64'(cnt_err1), 64'd1);
      chk("t4_err_with_rdy", 64'(cnt_rdy[1]), 64'd1);
      chk("t4_strb_cycles", 64'(cnt_strb3), 64'd3);

      // reset during ACCESS after m0 last served: must restore m0 priority
      slv_wait = 1;
      xfer(0, 32'h4000, 0, 32'h0, 4'hF);
      slv_wait = 1000;
      drive(1, 1, 0, 32'h5000, 0, 32'h0, 4'hF);
      n = 0;
      do begin @(negedge clock); n++; end while (!out_penable && n < 20);
      chk("t5_reached_access", 64'(out_penable), 64'h1);
      @(posedge clock); #1; reset = 1;
      @(negedge clock);
      chk("t5_psel_in_reset", 64'(out_psel), 64'h0);
      @(posedge clock); #1; reset = 0; drive(1, 0, 0, 32'h0, 0, 32'h0, 4'h0);
      @(negedge clock);
      chk("t5_idle_after_reset", 64'(out_psel), 64'h0);
      @(posedge clock); #1;
      drive(0, 1, 0, 32'h6000, 0, 32'h0, 4'hF);
      drive(1, 1, 0, 32'h7000, 0, 32'h0, 4'hF);
      @(posedge clock); #1;
      @(negedge clock);
      chk("t5_grant_m0_addr", 64'(out_paddr), 64'h6000);
      chk("t5_setup_phase", 64'({out_psel, out_penable}), 64'b10);
      @(posedge clock); #1;
      drive(0, 0, 0, 32'h0, 0, 32'h0, 4'h0);
      drive(1, 0, 0, 32'h0, 0, 32'h0, 4'h0);
      do_reset(2);

      // randomized traffic
      rand_mode = 1;
      fork
         repeat (40) begin
            repeat ($urandom_range(0, 3)) begin @(posedge clock); #1; end
            xfer(0, $urandom, 1'($urandom_range(0, 1)), $urandom, 4'($urandom));
         end
         repeat (40) begin
            repeat ($urandom_range(0, 3)) begin @(posedge clock); #1; end
            xfer(1, $urandom, 1'($urandom_range(0, 1)), $urandom, 4'($urandom));
         end
      join
      rand_mode = 0;
      repeat (3) @(posedge clock);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end
endmodule

// File: doc/sdram_apb_arbiter.md
Name: sdram_apb_arbiter

Overview:
- Two-requester APB arbiter in front of the single APB slave port of the SDRAM controller.
- Requester m0 is the CPU LSU; requester m1 is instruction fetch or DMA.
- Round-robin grant. Once granted, a requester owns the downstream port until its transfer completes.
- Regenerates a clean SETUP→ACCESS sequence downstream, since the SDRAM bridge samples requests only in the psel && !penable cycle.

Parameters:
- ADDR_W, 32, address width of all ports
- DATA_W, 32, data width; strobe width is DATA_W/8
- TIMEOUT_CYCLES, 1024, ACCESS-phase cycle limit (used only with the optional feature)

Ports:
- clock  input  1  system clock
- reset  input  1  synchronous, active-high
- m0_psel/m0_penable/m0_pwrite  input  1 each  requester 0 APB control
- m0_paddr  input  ADDR_W  requester 0 address
- m0_pprot  input  3  requester 0 protection
- m0_pwdata  input  DATA_W  requester 0 write data
- m0_pstrb  input  DATA_W/8  requester 0 byte strobes
- m0_pready/m0_pslverr  output  1 each  requester 0 completion / error
- m0_prdata  output  DATA_W  requester 0 read data
- m1_*  same set and widths as m0_*, for requester 1
- out_psel/out_penable/out_pwrite  output  1 each  downstream APB control
- out_paddr  output  ADDR_W  downstream address
- out_pprot  output  3  downstream protection
- out_pwdata  output  DATA_W  downstream write data
- out_pstrb  output  DATA_W/8  downstream strobes
- out_pready/out_pslverr  input  1 each  downstream completion / error
- out_prdata  input  DATA_W  downstream read data

Behaviour:
- Clocking: clock is the clock; reset is synchronous, active-high.
- Registered state: state (IDLE, SETUP, ACCESS; plus DRAIN with the optional feature), grant (1 bit), last (1 bit, last served requester).
- Reset values: state=IDLE, last=1 (so m0 wins first), grant=0.
- Outputs during and after reset: all out_* = 0; all mX_pready, mX_pslverr, mX_prdata = 0.
- Request definition: mX_psel=1. Requests are sampled only in IDLE.
- IDLE, no request: stay in IDLE.
- IDLE, one request: grant that requester, go to SETUP.
- IDLE, both requesting: grant = ~last, go to SETUP.
- SETUP: out_psel=1, out_penable=0. Always exactly one cycle, then go to ACCESS.
- ACCESS: out_psel=1, out_penable=1.
  - While out_pready=0: stay in ACCESS.
  - When out_pready=1: m[grant]_pready=1 for that cycle; m[grant]_prdata=out_prdata and m[grant]_pslverr=out_pslverr (combinational pass-through); last<=grant; go to IDLE.
- Downstream payload in SETUP/ACCESS: out_paddr/pwrite/pwdata/pstrb/pprot are combinationally muxed from m[grant]. APB requires requesters to hold these stable until pready.
- Downstream outputs in IDLE: out_psel=0, out_penable=0; all payload outputs driven 0.
- Non-granted requester: pready=0, pslverr=0, prdata=0 at all times. Its request stays pending with no timeout.
- Latency: requester psel at cycle 0 → out SETUP at cycle 1 → out ACCESS at cycle 2.
  - Minimum total is 3 cycles, with mX_pready at cycle 2 if out_pready=1 that cycle.
  - Back-to-back: next grant's SETUP no earlier than 2 cycles after the previous completion, because one IDLE cycle is required.
- Fairness: with both requesters continuously active, grants alternate m0, m1, m0, ...
- Protocol-violating requester: a requester that deasserts psel while granted is ignored. The transfer runs to downstream completion, and the pready pulse goes to the granted index.
- Reset mid-transfer: return to IDLE immediately. A downstream transfer in flight is abandoned; the system reset also resets the SDRAM controller.

Optional Feature:
- Macro: SDRAM_APB_ARB_TIMEOUT_EN.
- Enabled:
  - A cycle counter clears on entering ACCESS and increments each ACCESS cycle.
  - If it reaches TIMEOUT_CYCLES-1 with out_pready=0: complete to m[grant] with pready=1, pslverr=1, prdata=0; set last<=grant; go to DRAIN.
  - DRAIN: out_psel=0, out_penable=0. Wait for out_pready=1 and discard its data, then go to IDLE. No grant is issued in DRAIN.
  - Reset clears the counter.
- Disabled: no counter, no DRAIN state; ACCESS waits indefinitely.

Test Plan:
- m0 read 0xA000_0010 alone, out_pready asserted 4 cycles into ACCESS, out_prdata=0x1234_5678 → m0_pready single pulse with m0_prdata=0x1234_5678; out_psel high 5 cycles; out_penable low only in the first of them; m1_pready stays 0.
- m0 and m1 assert psel in the same cycle right after reset → m0 served first, then m1 SETUP exactly 2 cycles after m0_pready.
- Both requesters issue 4 back-to-back writes each, out_pready immediate → grant order m0,m1,m0,m1,m0,m1,m0,m1; out_paddr/pwdata/pstrb match the granted requester in every SETUP cycle.
- m1 write with pstrb=4'b0011 and out_pslverr=1 on completion → m1_pslverr=1 only in the m1_pready cycle; out_pstrb=4'b0011 throughout SETUP/ACCESS.
- Reset asserted during ACCESS → next cycle out_psel=0 and state IDLE; a subsequent simultaneous request grants m0.
- With SDRAM_APB_ARB_TIMEOUT_EN and TIMEOUT_CYCLES=8, out_pready held low → m0_pready=1, m0_pslverr=1 on the 8th ACCESS cycle; no new SETUP until out_pready pulses.
